sample_accumulator_ctrl: RTL and testbench
==========================================

Name: sample_accumulator_ctrl

Overview:
- Sequencer that sits directly upstream of the team's 16+8-bit pipelined adder and also consumes its 17-bit result.
- Accepts a stream of 8-bit samples over a valid/ready handshake and drives the adder with (running sum, sample).
- Captures each adder result back into the running sum, saturating on carry-out.
- Reports the final 16-bit sum and a sticky overflow flag after a programmed number of samples.

Parameters:
- COUNT_WIDTH, 9, width of the sample-count input; max 2^COUNT_WIDTH-1 samples per run.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  begin a run; sampled only in IDLE.
- count  input  COUNT_WIDTH  number of samples in the run; latched on start.
- sample_in  input  8  sample data.
- sample_valid  input  1  sample_in holds a valid sample.
- sample_ready  output  1  block will accept a sample this cycle.
- add_in1  output  16  to adder in1: current running sum.
- add_in2  output  8  to adder in2: sample being added.
- add_out  input  17  from adder out; valid one cycle after the operands are presented.
- sum_out  output  16  running/final sum.
- overflow  output  1  sticky; set when any add carried out or saturated.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse when the run completes.

Behaviour:
- Reset is asynchronous, active-high; clock is clock.
- On reset:
  - state=IDLE, acc=0, remaining=0, overflow=0.
  - sum_out=0, done=0, busy=0, sample_ready=0.
  - add_in1=0, add_in2=0.
- States and transitions:
  - IDLE: start=1 → acc<=0, overflow<=0, remaining<=count.
    - count=0 → DONE.
    - Otherwise → ISSUE.
  - ISSUE:
    - sample_ready=1; add_in1=acc; add_in2 = sample_valid ? sample_in : 0.
    - sample_valid=1 (transfer) → CAPTURE.
    - Otherwise stay in ISSUE, with no limit on the stall.
  - CAPTURE:
    - sample_ready=0; add_in2=0; add_out now holds acc+sample.
    - add_out[16]=1 → acc<=16'hFFFF, overflow<=1.
    - Otherwise acc<=add_out[15:0].
    - remaining<=remaining-1; remaining==1 → DONE, otherwise → ISSUE.
  - DONE: done=1 for exactly one cycle → IDLE.
- Adder latency is fixed at 1 cycle, so throughput is 1 sample per 2 cycles at most.
- With continuous sample_valid, done is high in cycle 2N+1 after the edge that sampled start; count=0 gives done in cycle 1.
- sum_out = acc at all times.
  - Holds the final value in IDLE until the next start.
  - Clears to 0 on the edge that accepts start.
- Saturation:
  - Once acc=16'hFFFF with overflow=1, further adds keep acc at 16'hFFFF.
  - Overflow is not set by reaching 16'hFFFF exactly without carry-out.
- start while busy is ignored; count is not re-latched.
- sample_valid outside ISSUE is ignored and no data is consumed.
- sample_in must be stable while sample_valid=1 and sample_ready=0.
- add_in1/add_in2 are combinational from state, acc and sample_in; the adder registers them.
- The adder shares clock and reset with this block, so a mid-run reset leaves both clean.
- Reset mid-run: immediate return to IDLE, everything cleared, no done pulse; a new start is required.

Test Plan:
- Basic run: reset, start with count=3, samples 10,20,30 with continuous valid → done in cycle 7 after start, sum_out=60, overflow=0, busy falls with done.
- Zero count: start with count=0 → done in cycle 1, sum_out=0, sample_ready never asserted.
- Exact boundary: count=257, all samples 0xFF → sum_out=16'hFFFF, overflow=0. Repeat with count=258 → sum_out=16'hFFFF, overflow=1.
- Backpressure: count=2, samples 5 then 7, valid deasserted 4 cycles between them → FSM holds in ISSUE with sample_ready=1, sum_out=12, done in cycle 9.
- Reset mid-run: count=4, assert reset after the second sample → all outputs 0 immediately. Then start with count=1, sample 9 → sum_out=9, overflow=0.
- Start while busy: pulse start with count=1 during a count=3 run of 1,1,1 → ignored, sum_out=3, exactly one done pulse.

Source files
------------

// File: rtl/sample_accumulator_ctrl.sv
// Sequencer that feeds an external 1-cycle 16+8 adder with (running sum, sample)
// and folds each 17-bit result back into a saturating 16-bit accumulator.
module sample_accumulator_ctrl #(
    parameter int COUNT_WIDTH = 9
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic [7:0]             sample_in,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    output logic [15:0]            add_in1,
    output logic [7:0]             add_in2,
    input  logic [16:0]            add_out,
    output logic [15:0]            sum_out,
    output logic                   overflow,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } state_t;

    state_t                 state;
    logic [15:0]            acc;
    logic [COUNT_WIDTH-1:0] remaining;

    // Operands go out combinationally; the adder registers them on the same edge
    // that moves us from ISSUE to CAPTURE.
    assign add_in1 = acc;
    assign add_in2 = (state == ISSUE && sample_valid) ? sample_in : 8'h00;
    assign sum_out = acc;

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            remaining    <= '0;
            overflow     <= 1'b0;
            sample_ready <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            sample_ready <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        overflow  <= 1'b0;
                        remaining <= count;
                        busy      <= 1'b1;
                        if (count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= ISSUE;
                            sample_ready <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (sample_valid) begin
                        state <= CAPTURE;
                    end else begin
                        sample_ready <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (add_out[16]) begin
                        acc      <= 16'hFFFF;
                        overflow <= 1'b1;
                    end else begin
                        acc <= add_out[15:0];
                    end
                    remaining <= remaining - COUNT_WIDTH'(1);
                    if (remaining == COUNT_WIDTH'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state        <= ISSUE;
                        sample_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_accumulator_ctrl.sv
// Bench for sample_accumulator_ctrl: directed and random runs against a
// saturating-sum reference model, with a registered adder model alongside.
module tb_sample_accumulator_ctrl;

    localparam int CW = 9;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] count;
    logic [7:0]    sample_in;
    logic          sample_valid;
    logic          sample_ready;
    logic [15:0]   add_in1;
    logic [7:0]    add_in2;
    logic [16:0]   add_out;
    logic [15:0]   sum_out;
    logic          overflow;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;

    logic [7:0] samp_q[$];
    int         stall_q[$];

    always #5 clock = ~clock;

    // Stand-in for the downstream 16+8 pipelined adder: one register stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) add_out <= '0;
        else       add_out <= {1'b0, add_in1} + 17'(add_in2);
    end

    sample_accumulator_ctrl #(.COUNT_WIDTH(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .count        (count),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .add_in1      (add_in1),
        .add_in2      (add_in2),
        .add_out      (add_out),
        .sum_out      (sum_out),
        .overflow     (overflow),
        .busy         (busy),
        .done         (done)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Running sum that pins at 0xFFFF once a true carry-out occurs.
    function automatic void model(output logic [15:0] sum, output logic ov);
        int s;
        s  = 0;
        ov = 1'b0;
        foreach (samp_q[i]) begin
            s = s + int'(samp_q[i]);
            if (s > 65535) begin
                s  = 65535;
                ov = 1'b1;
            end
        end
        sum = 16'(s);
    endfunction

    task automatic apply_stimulus(input string tag, input int pulse_at);
        int          n;
        int          exp_cycle;
        int          cycle;
        int          idx;
        int          stall_left;
        bit          ready_seen;
        bit          transfer;
        logic [15:0] exp_sum;
        logic        exp_ov;

        n = samp_q.size();
        model(exp_sum, exp_ov);
        exp_cycle = 1 + 2 * n;
        foreach (stall_q[i]) exp_cycle += stall_q[i];

        @(negedge clock);
        start        = 1'b1;
        count        = CW'(n);
        sample_valid = 1'b0;
        @(posedge clock);
        #1;
        start      = 1'b0;
        cycle      = 1;
        idx        = 0;
        ready_seen = 1'b0;
        stall_left = (n > 0) ? stall_q[0] : 0;
        check_output({tag, ".sum_cleared"}, 32'(sum_out), 32'h0);
        check_output({tag, ".busy_start"}, 32'(busy), 32'h1);

        while (cycle < exp_cycle + 20) begin
            if (done) break;
            ready_seen |= sample_ready;
            start = (cycle == pulse_at);
            count = start ? CW'(1) : CW'(n);
            sample_valid = (idx < n) && (stall_left == 0);
            sample_in    = sample_valid ? samp_q[idx] : 8'($urandom);
            if (!sample_valid && sample_ready && stall_left > 0) stall_left--;
            transfer = sample_valid && sample_ready;
            @(posedge clock);
            #1;
            cycle++;
            if (transfer) begin
                idx++;
                stall_left = (idx < n) ? stall_q[idx] : 0;
            end
        end
        start        = 1'b0;
        sample_valid = 1'b0;

        check_output({tag, ".done_seen"}, 32'(done), 32'h1);
        check_output({tag, ".done_cycle"}, 32'(cycle), 32'(exp_cycle));
        check_output({tag, ".consumed"}, 32'(idx), 32'(n));
        check_output({tag, ".sum"}, 32'(sum_out), 32'(exp_sum));
        check_output({tag, ".overflow"}, 32'(overflow), 32'(exp_ov));
        check_output({tag, ".busy_at_done"}, 32'(busy), 32'h1);
        check_output({tag, ".ready_seen"}, 32'(ready_seen), 32'(n > 0));

        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            check_output({tag, ".done_low_after"}, 32'(done), 32'h0);
            check_output({tag, ".busy_low_after"}, 32'(busy), 32'h0);
            check_output({tag, ".sum_held"}, 32'(sum_out), 32'(exp_sum));
        end
        check_output({tag, ".ready_idle"}, 32'(sample_ready), 32'h0);
    endtask

    task automatic check_cleared(input string tag);
        check_output({tag, ".sum_out"}, 32'(sum_out), 32'h0);
        check_output({tag, ".overflow"}, 32'(overflow), 32'h0);
        check_output({tag, ".busy"}, 32'(busy), 32'h0);
        check_output({tag, ".done"}, 32'(done), 32'h0);
        check_output({tag, ".ready"}, 32'(sample_ready), 32'h0);
        check_output({tag, ".add_in1"}, 32'(add_in1), 32'h0);
        check_output({tag, ".add_in2"}, 32'(add_in2), 32'h0);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        count        = '0;
        sample_in    = '0;
        sample_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_cleared("reset");
        @(negedge clock);
        reset = 1'b0;

        samp_q = {8'd10, 8'd20, 8'd30};
        stall_q = {0, 0, 0};
        apply_stimulus("basic", -1);

        samp_q.delete();
        stall_q.delete();
        apply_stimulus("zero_count", -1);

        samp_q.delete();
        stall_q.delete();
        for (int i = 0; i < 257; i++) begin
            samp_q.push_back(8'hFF);
            stall_q.push_back(0);
        end
        apply_stimulus("exact_ffff", -1);
        samp_q.push_back(8'hFF);
        stall_q.push_back(0);
        apply_stimulus("carry_258", -1);

        samp_q = {8'd5, 8'd7};
        stall_q = {0, 4};
        apply_stimulus("backpressure", -1);

        // Abort a run after its second sample and confirm the block restarts clean.
        @(negedge clock);
        start = 1'b1;
        count = CW'(4);
        @(posedge clock);
        #1;
        start        = 1'b0;
        sample_valid = 1'b1;
        sample_in    = 8'd3;
        @(posedge clock);
        #1;
        sample_in = 8'd4;
        repeat (2) @(posedge clock);
        #1;
        sample_valid = 1'b0;
        check_output("midrun.sum_before", 32'(sum_out), 32'h3);
        reset = 1'b1;
        #1;
        check_cleared("midrun_reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_cleared("midrun_after");
        samp_q = {8'd9};
        stall_q = {0};
        apply_stimulus("after_reset", -1);

        samp_q = {8'd1, 8'd1, 8'd1};
        stall_q = {0, 0, 0};
        apply_stimulus("start_busy", 3);

        for (int t = 0; t < 8; t++) begin
            int n;
            n = int'($urandom_range(1, 12));
            samp_q.delete();
            stall_q.delete();
            for (int i = 0; i < n; i++) begin
                samp_q.push_back(8'($urandom));
                stall_q.push_back(int'($urandom_range(0, 3)));
            end
            apply_stimulus($sformatf("rand%0d", t), int'($urandom_range(1, 4)));
        end

        samp_q.delete();
        stall_q.delete();
        for (int i = 0; i < 300; i++) begin
            samp_q.push_back(8'($urandom_range(128, 255)));
            stall_q.push_back(int'($urandom_range(0, 1)));
        end
        apply_stimulus("rand_saturate", -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
